// File: rtl/panda_risc_v_div_pkg.sv
// rtl/panda_risc_v_div_pkg.sv - funct encodings, tag entry type and local-result constants for the divider issue block
package panda_risc_v_div_pkg;

  localparam logic [1:0] FUNCT_DIV  = 2'b00;
  localparam logic [1:0] FUNCT_DIVU = 2'b01;
  localparam logic [1:0] FUNCT_REM  = 2'b10;
  localparam logic [1:0] FUNCT_REMU = 2'b11;

  typedef struct packed {
    logic [4:0] rd;
    logic       kill;
  } div_tag_t;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT      = 32'h8000_0000;
  localparam logic [31:0] OVF_REM       = 32'h0000_0000;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  function automatic logic is_signed_op(input logic [1:0] funct);
    return (funct == FUNCT_DIV) || (funct == FUNCT_REM);
  endfunction

  function automatic logic [32:0] extend_op(input logic [31:0] v, input logic sgn);
    return {sgn & v[31], v};
  endfunction

endpackage

// File: rtl/panda_risc_v_div_tag_fifo.sv
// rtl/panda_risc_v_div_tag_fifo.sv - in-flight destination tag FIFO with flush-all-kill
module panda_risc_v_div_tag_fifo
  import panda_risc_v_div_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [4:0]               push_rd,
  input  logic                     pop,
  input  logic                     flush,
  output div_tag_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  div_tag_t      mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // an entry pushed during a flush is written already killed
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) mem[i].kill <= 1'b1;
    end
    if (push) mem[wptr] <= '{rd: push_rd, kill: flush};
  end

  assign head  = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/panda_risc_v_div_issue.sv
// rtl/panda_risc_v_div_issue.sv - RV32M divider issue/writeback controller with in-order tag tracking
// PANDA_DIV_LOCAL_EXCEPT_EN: resolve divide-by-zero and signed overflow locally, never issuing them.
module panda_risc_v_div_issue
  import panda_risc_v_div_pkg::*;
#(
  parameter int MAX_OUTSTANDING  = 4,
  parameter int simulation_delay = 1
)(
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] s_req_op_a,
  input  logic [31:0] s_req_op_b,
  input  logic [1:0]  s_req_funct,
  input  logic [4:0]  s_req_rd,
  input  logic        s_req_valid,
  output logic        s_req_ready,
  output logic [32:0] m_div_req_op_a,
  output logic [32:0] m_div_req_op_b,
  output logic        m_div_req_rem_sel,
  output logic        m_div_req_valid,
  input  logic        m_div_req_ready,
  input  logic [31:0] s_div_res_data,
  input  logic        s_div_res_valid,
  output logic        s_div_res_ready,
  output logic [31:0] m_wb_data,
  output logic [4:0]  m_wb_rd,
  output logic        m_wb_valid,
  input  logic        m_wb_ready,
  input  logic        flush,
  output logic        busy
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(MAX_OUTSTANDING);

  logic          issue_valid;
  logic [32:0]   issue_op_a;
  logic [32:0]   issue_op_b;
  logic          issue_rem_sel;
  logic [4:0]    issue_rd;
  logic          wb_valid;
  logic [31:0]   wb_data;
  logic [4:0]    wb_rd;

  div_tag_t      head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          req_signed;
  logic          push;
  logic          pop;
  logic          head_kill;
  logic          res_load;
  logic          req_fire;
  logic          issue_load;
  logic          exc_load;
  logic          ready_norm;
  logic          local_exc;
  logic [31:0]   local_res;
  logic [CW:0]   in_flight;

  assign req_signed      = is_signed_op(s_req_funct);
  assign push            = issue_valid & m_div_req_ready;
  assign head_kill       = ~fifo_empty & head.kill;
  assign s_div_res_ready = head_kill | ~wb_valid | m_wb_ready;
  assign pop             = s_div_res_valid & s_div_res_ready & ~fifo_empty;
  assign res_load        = pop & ~head.kill & ~flush;

  // ops that will be outstanding once the issue register drains, net of a same-cycle pop
  assign in_flight  = {1'b0, fifo_count} + (CW+1)'(issue_valid) - (CW+1)'(pop);
  assign ready_norm = ~flush & (~issue_valid | m_div_req_ready) & (in_flight < LIMIT);

`ifdef PANDA_DIV_LOCAL_EXCEPT_EN
  logic div_zero;
  logic overflow;
  logic ready_exc;

  assign div_zero    = (s_req_op_b == '0);
  assign overflow    = req_signed & (s_req_op_a == INT_MIN) & (s_req_op_b == '1);
  assign local_exc   = div_zero | overflow;
  assign local_res   = div_zero ? (s_req_funct[1] ? s_req_op_a : DIV_ZERO_QUOT)
                                : (s_req_funct[1] ? OVF_REM : OVF_QUOT);
  // a local result may only overtake nothing, so the pipe must be empty
  assign ready_exc   = ~flush & ~issue_valid & fifo_empty & (~wb_valid | m_wb_ready);
  assign s_req_ready = local_exc ? ready_exc : ready_norm;
`else
  assign local_exc   = 1'b0;
  assign local_res   = '0;
  assign s_req_ready = ready_norm;
`endif

  assign req_fire   = s_req_valid & s_req_ready;
  assign issue_load = req_fire & ~local_exc;
  assign exc_load   = req_fire & local_exc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issue_valid <= 1'b0;
      wb_valid    <= 1'b0;
    end else begin
      if (flush)           issue_valid <= 1'b0;
      else if (issue_load) issue_valid <= 1'b1;
      else if (push)       issue_valid <= 1'b0;

      if (flush)                     wb_valid <= 1'b0;
      else if (res_load || exc_load) wb_valid <= 1'b1;
      else if (m_wb_ready)           wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (issue_load) begin
      issue_op_a    <= extend_op(s_req_op_a, req_signed);
      issue_op_b    <= extend_op(s_req_op_b, req_signed);
      issue_rem_sel <= s_req_funct[1];
      issue_rd      <= s_req_rd;
    end
    if (res_load) begin
      wb_data <= s_div_res_data;
      wb_rd   <= head.rd;
    end else if (exc_load) begin
      wb_data <= local_res;
      wb_rd   <= s_req_rd;
    end
  end

  panda_risc_v_div_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .push_rd(issue_rd),
    .pop    (pop),
    .flush  (flush),
    .head   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign m_div_req_op_a    = issue_op_a;
  assign m_div_req_op_b    = issue_op_b;
  assign m_div_req_rem_sel = issue_rem_sel;
  assign m_div_req_valid   = issue_valid;
  assign m_wb_data         = wb_data;
  assign m_wb_rd           = wb_rd;
  assign m_wb_valid        = wb_valid;
  assign busy              = issue_valid | ~fifo_empty | wb_valid;

  always @(posedge clk) begin
    if (resetn) begin
      assert (!(s_div_res_valid && fifo_empty))
        else $error("divider result returned with no tag in flight (sim delay %0d)", simulation_delay);
      assert (!(push && fifo_full && !pop))
        else $error("tag fifo overflow");
    end
  end

endmodule

// File: tb/tb_panda_risc_v_div_issue.sv
// tb/tb_panda_risc_v_div_issue.sv - directed bench with a request-level scoreboard and divider model
module tb_panda_risc_v_div_issue;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s_req_op_a = '0, s_req_op_b = '0;
  logic [1:0]  s_req_funct = '0;
  logic [4:0]  s_req_rd = '0;
  logic        s_req_valid = 1'b0, s_req_ready;
  logic [32:0] m_div_req_op_a, m_div_req_op_b;
  logic        m_div_req_rem_sel, m_div_req_valid;
  logic        m_div_req_ready = 1'b1;
  logic [31:0] s_div_res_data = '0;
  logic        s_div_res_valid = 1'b0, s_div_res_ready;
  logic [31:0] m_wb_data;
  logic [4:0]  m_wb_rd;
  logic        m_wb_valid;
  logic        m_wb_ready = 1'b1;
  logic        flush = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  panda_risc_v_div_issue #(.MAX_OUTSTANDING(4), .simulation_delay(1)) dut (
    .clk(clk), .resetn(resetn),
    .s_req_op_a(s_req_op_a), .s_req_op_b(s_req_op_b), .s_req_funct(s_req_funct),
    .s_req_rd(s_req_rd), .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .m_div_req_op_a(m_div_req_op_a), .m_div_req_op_b(m_div_req_op_b),
    .m_div_req_rem_sel(m_div_req_rem_sel), .m_div_req_valid(m_div_req_valid),
    .m_div_req_ready(m_div_req_ready),
    .s_div_res_data(s_div_res_data), .s_div_res_valid(s_div_res_valid),
    .s_div_res_ready(s_div_res_ready),
    .m_wb_data(m_wb_data), .m_wb_rd(m_wb_rd), .m_wb_valid(m_wb_valid), .m_wb_ready(m_wb_ready),
    .flush(flush), .busy(busy)
  );

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } wb_exp_t;
  typedef struct packed { logic [32:0] a; logic [32:0] b; logic rs; } iss_t;

  wb_exp_t     exp_q[$];
  iss_t        iss_q[$];
  logic [31:0] div_q[$];
  logic [4:0]  wb_log[$];
  int          checks = 0, errors = 0, cycle = 0, div_fires = 0, wb_fires = 0;
  logic        res_en = 1'b1;
  logic        wb_hold = 1'b0, iss_hold = 1'b0;
  logic [37:0] held_wb;
  logic [67:0] held_req;
  iss_t        last_iss;
  logic [4:0]  last_wb_rd;
  logic [31:0] last_wb_data;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // architectural RV32M result of the original request
  function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
      return f[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return f[1] ? a % b : a / b;
  endfunction

  function automatic logic [32:0] ext(input logic [31:0] v, input logic [1:0] f);
    return {~f[0] & v[31], v};
  endfunction

  function automatic logic is_local(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef PANDA_DIV_LOCAL_EXCEPT_EN
    return (b == 32'h0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`else
    return 1'b0;
`endif
  endfunction

  // the divider works on the 33-bit signed operands it is handed
  function automatic logic [31:0] div33(input iss_t x);
    logic signed [32:0] sa, sb, q, r;
    sa = x.a;
    sb = x.b;
    if (sb == 0) begin q = '1; r = sa; end
    else begin q = sa / sb; r = sa % sb; end
    return x.rs ? r[31:0] : q[31:0];
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (!resetn) begin
        exp_q.delete(); iss_q.delete(); div_q.delete();
        wb_hold = 1'b0; iss_hold = 1'b0;
      end else begin
        if (wb_hold) check("wb_stable", {m_wb_valid, m_wb_rd, m_wb_data}, held_wb);
        if (iss_hold) check("req_stable", {m_div_req_valid, m_div_req_op_a, m_div_req_op_b, m_div_req_rem_sel}, held_req);
        if (s_div_res_valid && s_div_res_ready && div_q.size() > 0) div_q.delete(0);
        if (m_div_req_valid && m_div_req_ready) begin
          div_fires++;
          last_iss = {m_div_req_op_a, m_div_req_op_b, m_div_req_rem_sel};
          if (iss_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL issue_unexpected: got op_a %h, expected no issue", m_div_req_op_a);
          end else begin
            check("issue_ops", last_iss, iss_q[0]);
            iss_q.delete(0);
          end
          div_q.push_back(div33(last_iss));
        end
        if (m_wb_valid && m_wb_ready) begin
          wb_fires++;
          wb_log.push_back(m_wb_rd);
          last_wb_rd = m_wb_rd;
          last_wb_data = m_wb_data;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected: got rd %0d data %h, expected no writeback", m_wb_rd, m_wb_data);
          end else begin
            check("wb", {m_wb_rd, m_wb_data}, exp_q[0]);
            exp_q.delete(0);
          end
        end
        if (s_req_valid && s_req_ready) begin
          if (!is_local(s_req_funct, s_req_op_a, s_req_op_b))
            iss_q.push_back({ext(s_req_op_a, s_req_funct), ext(s_req_op_b, s_req_funct), s_req_funct[1]});
          exp_q.push_back({s_req_rd, ref_result(s_req_funct, s_req_op_a, s_req_op_b)});
        end
        if (flush) begin exp_q.delete(); iss_q.delete(); end
        wb_hold  = m_wb_valid && !m_wb_ready && !flush;
        held_wb  = {m_wb_valid, m_wb_rd, m_wb_data};
        iss_hold = m_div_req_valid && !m_div_req_ready && !flush;
        held_req = {m_div_req_valid, m_div_req_op_a, m_div_req_op_b, m_div_req_rem_sel};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      s_div_res_valid = resetn && res_en && (div_q.size() > 0);
      s_div_res_data  = (div_q.size() > 0) ? div_q[0] : 32'h0;
    end
  end

  task automatic wait_accept();
    int n = 0;
    do begin @(negedge clk); n++; end while (!s_req_ready && n < 200);
    if (!s_req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: got s_req_ready=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    s_req_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    s_req_funct = f; s_req_op_a = a; s_req_op_b = b; s_req_rd = rd; s_req_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || div_q.size() > 0 || exp_q.size() > 0) && n < 300);
    if (busy || exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d, expected idle", busy, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n, c0, f0, w0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_req_ready", s_req_ready, 1);
    check("rst_m_div_req_valid", m_div_req_valid, 0);
    check("rst_s_div_res_ready", s_div_res_ready, 1);
    check("rst_m_wb_valid", m_wb_valid, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1; resetn = 1'b1;

    send(DIV, 32'hFFFF_FFF9, 32'h2, 5'd5);
    wait_idle();
    check("div_issue_ops", last_iss, {33'h1_FFFF_FFF9, 33'h0_0000_0002, 1'b0});
    check("div_wb", {last_wb_rd, last_wb_data}, {5'd5, 32'hFFFF_FFFD});

    send(REMU, 32'hFFFF_FFFF, 32'h10, 5'd12);
    wait_idle();
    check("remu_issue_ops", last_iss, {33'h0_FFFF_FFFF, 33'h0_0000_0010, 1'b1});
    check("remu_wb", {last_wb_rd, last_wb_data}, {5'd12, 32'h0000_000F});

    res_en = 1'b0;
    for (int i = 1; i <= 4; i++) send(DIVU, 32'(100 * i), 32'(i + 1), 5'(i));
    s_req_funct = DIV; s_req_op_a = 32'd77; s_req_op_b = 32'd7; s_req_rd = 5'd13; s_req_valid = 1'b1;
    repeat (5) begin @(negedge clk); check("fill_blocked", s_req_ready, 0); end
    @(posedge clk); #1; res_en = 1'b1;
    wait_accept();
    wait_idle();
    n = wb_log.size();
    check("fill_order", {wb_log[n-5], wb_log[n-4], wb_log[n-3], wb_log[n-2], wb_log[n-1]},
          {5'd1, 5'd2, 5'd3, 5'd4, 5'd13});

    res_en = 1'b0;
    send(DIV, 32'd50, 32'd5, 5'd6);
    send(REM, 32'd50, 32'd7, 5'd7);
    send(DIVU, 32'd9, 32'd3, 5'd8);
    n = 0;
    do begin @(negedge clk); n++; end while (m_div_req_valid && n < 20);
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    w0 = wb_fires; res_en = 1'b1;
    wait_idle();
    check("flush_no_wb", wb_fires - w0, 0);
    send(DIV, 32'd100, 32'd7, 5'd9);
    wait_idle();
    check("post_flush_wb", {last_wb_rd, last_wb_data}, {5'd9, 32'd14});

    m_div_req_ready = 1'b0; f0 = div_fires;
    send(DIV, 32'd8, 32'd2, 5'd10);
    repeat (2) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; m_div_req_ready = 1'b1;
    wait_idle();
    check("flush_issue_killed", div_fires - f0, 0);

    m_wb_ready = 1'b0;
    send(DIV, 32'd1000, 32'd10, 5'd20);
    send(REM, 32'hFFFF_FFF9, 32'd2, 5'd21);
    n = 0;
    do begin @(negedge clk); n++; end while (!m_wb_valid && n < 50);
    check("bp_wb_valid", m_wb_valid, 1);
    repeat (10) begin @(negedge clk); check("bp_res_ready", s_div_res_ready, 0); end
    check("bp_data", {m_wb_rd, m_wb_data}, {5'd20, 32'd100});
    @(posedge clk); #1; m_wb_ready = 1'b1;
    wait_idle();
    n = wb_log.size();
    check("bp_order", {wb_log[n-2], wb_log[n-1], last_wb_data}, {5'd20, 5'd21, 32'hFFFF_FFFF});

    c0 = cycle;
    send(DIV, 32'd100, 32'd3, 5'd1);
    send(DIVU, 32'hF000_0000, 32'd16, 5'd2);
    send(REM, 32'hFFFF_FF9C, 32'd7, 5'd3);
    send(REMU, 32'd123456, 32'd1000, 5'd4);
    send(DIV, 32'h8000_0000, 32'd2, 5'd5);
    send(DIV, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    send(REM, 32'h8000_0001, 32'hFFFF_FFF0, 5'd7);
    send(DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    check("throughput_cycles", cycle - c0, 8);
    wait_idle();

    f0 = div_fires;
    send(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22);
    wait_idle();
    check("exc_rem_ovf", {last_wb_rd, last_wb_data}, {5'd22, 32'h0});
    send(DIVU, 32'd7, 32'd0, 5'd23);
    wait_idle();
    check("exc_divu_zero", {last_wb_rd, last_wb_data}, {5'd23, 32'hFFFF_FFFF});
    send(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd24);
    send(REMU, 32'd9, 32'd0, 5'd25);
    send(DIV, 32'hFFFF_FFFB, 32'd0, 5'd26);
    wait_idle();
    check("exc_last", {last_wb_rd, last_wb_data}, {5'd26, 32'hFFFF_FFFF});
`ifdef PANDA_DIV_LOCAL_EXCEPT_EN
    check("exc_never_issued", div_fires - f0, 0);
`else
    check("exc_all_issued", div_fires - f0, 5);
`endif

    res_en = 1'b0;
    send(DIV, 32'd10, 32'd3, 5'd27);
    send(DIV, 32'd11, 32'd3, 5'd28);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_state", {busy, m_wb_valid, m_div_req_valid, s_div_res_ready}, 4'b0001);
    @(posedge clk); #1; resetn = 1'b1; res_en = 1'b1;
    send(DIV, 32'd42, 32'd6, 5'd30);
    wait_idle();
    check("midrst_after", {last_wb_rd, last_wb_data, busy}, {5'd30, 32'd7, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/panda_risc_v_div_issue.md
# panda_risc_v_div_issue

Issue/writeback controller for the multi-cycle divider in the EXU. Accepts RV32M DIV/DIVU/REM/REMU requests, extends operands to 33 bits and issues them on the divider request handshake. It tracks in-flight destination tags, pairs each returned divider result with its `rd`, and presents an in-order writeback stream. A pipeline flush kills every in-flight operation.

## Interface
- `MAX_OUTSTANDING`, 4: maximum divider ops in flight, i.e. issued but result not yet accepted. Power of 2, at least 2.
- `simulation_delay`, 1: register-update delay for simulation.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset, asynchronous, active-low
- `s_req_op_a`  in  32  rs1 value (dividend)
- `s_req_op_b`  in  32  rs2 value (divisor)
- `s_req_funct`  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- `s_req_rd`  in  5  destination register
- `s_req_valid` / `s_req_ready`  in/out  1  request handshake
- `m_div_req_op_a` / `m_div_req_op_b`  out  33  extended operands
- `m_div_req_rem_sel`  out  1  0 quotient, 1 remainder
- `m_div_req_valid` / `m_div_req_ready`  out/in  1
- `s_div_res_data`  in  32  divider result
- `s_div_res_valid` / `s_div_res_ready`  in/out  1
- `m_wb_data`  out  32; `m_wb_rd`  out  5
- `m_wb_valid` / `m_wb_ready`  out/in  1
- `flush`  in  1  kill all uncommitted ops
- `busy`  out  1  issue reg valid, or outstanding ≠ 0, or wb reg valid

## Operation
- **Operand extension**
  - Signed ops (funct[0]=0): bit32 = bit31.
  - Unsigned ops: bit32 = 0.
  - `rem_sel` = funct[1].
- **Issue register.** One entry holding the operands, `rem_sel` and `rd`; it drives `m_div_req_*`.
  - `s_req_ready` = ~flush & (~issue_valid | m_div_req_ready) & (outstanding + issue_valid < MAX_OUTSTANDING, after counting a same-cycle pop).
- **Tag FIFO.** Depth MAX_OUTSTANDING; each entry is {rd, kill}.
  - Push on `m_div_req_valid & m_div_req_ready`.
  - Pop on `s_div_res_valid & s_div_res_ready`.
  - A result with the divider valid but the FIFO empty is a protocol error; a simulation assertion flags it.
- **Result pairing**
  - Head kill=0: the result loads the writeback register with data and head rd.
  - Head kill=1: the result is accepted and dropped.
  - `s_div_res_ready` = head_kill | ~wb_valid | m_wb_ready.
- **Flush**
  - Sets kill on every FIFO entry, including an entry pushed in the same cycle.
  - Clears issue_valid, unless the divider accepts that same cycle; in that case the entry is pushed killed.
  - Clears wb_valid.
  - A result accepted in the flush cycle is dropped.
- **Ordering.** Writeback order equals request order; the divider is strictly in-order.

## Timing
- Reset values: `s_req_ready` 1; `m_div_req_valid` 0; `s_div_res_ready` 1; `m_wb_valid` 0; `busy` 0. Data outputs are undefined.
- Request accepted in cycle T → `m_div_req_valid` at T+1.
- Result accepted in cycle T → `m_wb_valid` at T+1.
- All outputs stay stable while valid and not ready.
- Full throughput: one request per cycle when the downstream side is always ready.
- Outstanding counter: simultaneous push and pop leaves it unchanged. Its width is log2(MAX_OUTSTANDING)+1.
- Reset mid-operation clears all state; the divider shares `resetn`.

## Configuration
- **`PANDA_DIV_LOCAL_EXCEPT_EN` defined:** divide-by-zero and signed overflow (a=0x80000000, b=0xFFFFFFFF) are resolved locally and never issued.
  - Divide-by-zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - Overflow: DIV → 0x80000000; REM → 0.
  - Such a request is accepted only when issue_valid=0, outstanding=0 and the wb reg is free or draining.
  - It loads the wb reg at T+1.
- **Undefined:** all requests go to the divider, which produces the same values.

## Structure
- Package `panda_risc_v_div_pkg` holds:
  - funct encodings;
  - the tag entry struct {rd, kill};
  - constants for the div-by-zero and overflow results.
- Sub-module `panda_risc_v_div_tag_fifo`: register FIFO with a flush-all-kill port, plus full/empty and count outputs.

## Test plan
- **Signed DIV:** DIV 0xFFFFFFF9/0x00000002, rd=5.
  - Issue shows op_a 0x1_FFFFFFF9, op_b 0x0_00000002, rem_sel 0.
  - Divider returns 0xFFFFFFFD → wb rd=5, data 0xFFFFFFFD.
- **Unsigned extension:** REMU 0xFFFFFFFF/0x10 → op_a 0x0_FFFFFFFF, rem_sel 1; result 0xF written to the given rd.
- **In-order fill:** four back-to-back requests rd 1..4 with the divider result stalled → fifth request sees `s_req_ready`=0 until the first result is accepted; wb order is 1,2,3,4.
- **Flush:** flush with 3 outstanding → 3 results consumed, no `m_wb_valid`. The next request (rd=9) writes back correctly.
- **Writeback backpressure:** `m_wb_ready`=0 for 10 cycles with a result pending → wb data held stable, `s_div_res_ready`=0 while wb_valid.
- **Local exceptions (macro on):**
  - REM 0x80000000/0xFFFFFFFF → wb 0 with `m_div_req_valid` never asserted.
  - DIVU 7/0 → 0xFFFFFFFF.
